// File: rtl/mem_arbiter.sv
// mem_arbiter: single owner of the 8-bit RAM/IO bus. Serves IF fetches and MEM
// loads/stores as byte beats, assembles read data little-endian and extends loads.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter bit          MEM_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [2:0] {S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [1:0]        iss_q, iss_d;
    logic [1:0]        cap_q, cap_d;
    logic              vld_q, vld_d;
    logic              rdy_q;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              if_pend, take_mem, take_if;
    logic              rd_state, capture, rd_last, wr_last;
    logic [1:0]        iss_nx;
    logic [1:0]        mem_last;
    logic [31:0]       asm_cap, ld_ext;

    assign if_pend  = if_req & ~flush;
    assign take_mem = mem_req & (MEM_PRIORITY | ~if_pend);
    assign take_if  = if_pend & ~take_mem;
    assign rd_state = (state_q == S_IF_RD) || (state_q == S_MEM_RD);
    assign capture  = rdy & rdy_q & vld_q & rd_state & ~((state_q == S_IF_RD) & flush);
    assign rd_last  = capture & (cap_q == last_q);
    assign wr_last  = rdy & (state_q == S_MEM_WR) & (iss_q == last_q);
    assign iss_nx   = iss_q + 2'd1;

    // Index of the final byte for a MEM access of the requested size
    always_comb begin
        case (mem_size)
            2'd0:    mem_last = 2'd0;
            2'd1:    mem_last = 2'd1;
            default: mem_last = 2'd3;
        endcase
    end

    // Assembly register with the byte arriving this cycle merged in
    always_comb begin
        asm_cap = asm_q;
        asm_cap[{cap_q, 3'b000} +: 8] = ram_din;
    end

    // Sign/zero extension of the completed load
    always_comb begin
        case (size_q)
            2'd0:    ld_ext = {{24{sext_q & asm_cap[7]}}, asm_cap[7:0]};
            2'd1:    ld_ext = {{16{sext_q & asm_cap[15]}}, asm_cap[15:0]};
            default: ld_ext = asm_cap;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; a paused cycle never advances the FSM
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (take_mem)     state_d = mem_we ? S_MEM_WR : S_MEM_RD;
                    else if (take_if) state_d = S_IF_RD;
                end
                S_IF_RD: begin
                    if (flush)        state_d = S_IDLE;
                    else if (rd_last) state_d = S_DONE;
                end
                S_MEM_RD: if (rd_last) state_d = S_DONE;
                S_MEM_WR: if (wr_last) state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        base_d      = base_q;
        wdata_d     = wdata_q;
        last_d      = last_q;
        size_d      = size_q;
        sext_d      = sext_q;
        iss_d       = iss_q;
        cap_d       = cap_q;
        vld_d       = vld_q;
        asm_d       = asm_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (take_mem || take_if) begin
                        base_d     = take_mem ? mem_addr : if_addr;
                        ram_a_d    = take_mem ? mem_addr : if_addr;
                        wdata_d    = take_mem ? mem_wdata : '0;
                        size_d     = take_mem ? mem_size : 2'd2;
                        sext_d     = take_mem & mem_signed;
                        last_d     = take_mem ? mem_last : 2'd3;
                        ram_wr_d   = take_mem & mem_we;
                        ram_dout_d = (take_mem & mem_we) ? mem_wdata[7:0] : '0;
                        iss_d      = '0;
                        cap_d      = '0;
                        vld_d      = 1'b0;
                        asm_d      = '0;
                    end
                end
                S_IF_RD, S_MEM_RD: begin
                    if (!((state_q == S_IF_RD) && flush)) begin
                        if (!rdy_q) begin
                            // First cycle after a pause: ram_din no longer matches the
                            // byte awaiting capture, so re-issue that byte's address and
                            // resume the issue/capture pipeline from it.
                            ram_a_d = base_q + ADDR_W'(cap_q);
                            iss_d   = cap_q;
                            vld_d   = 1'b0;
                        end else begin
                            if (capture) begin
                                asm_d = asm_cap;
                                cap_d = cap_q + 2'd1;
                            end
                            if (rd_last) begin
                                if (state_q == S_IF_RD) begin
                                    if_done_d = 1'b1;
                                    if_inst_d = asm_cap;
                                end else begin
                                    mem_done_d  = 1'b1;
                                    mem_rdata_d = ld_ext;
                                end
                            end
                            if (iss_q != last_q) begin
                                iss_d   = iss_nx;
                                ram_a_d = base_q + ADDR_W'(iss_nx);
                            end
                            vld_d = 1'b1;
                        end
                    end
                end
                S_MEM_WR: begin
                    if (iss_q != last_q) begin
                        iss_d      = iss_nx;
                        ram_a_d    = base_q + ADDR_W'(iss_nx);
                        ram_dout_d = wdata_q[{iss_nx, 3'b000} +: 8];
                    end else begin
                        ram_wr_d    = 1'b0;
                        mem_done_d  = 1'b1;
                        mem_rdata_d = '0;
                    end
                end
                S_DONE: begin
                    if_done_d  = 1'b0;
                    mem_done_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; rdy_q tracks the previous cycle's rdy even while paused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            wdata_q     <= '0;
            last_q      <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            iss_q       <= '0;
            cap_q       <= '0;
            vld_q       <= 1'b0;
            rdy_q       <= 1'b1;
            asm_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            last_q      <= last_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            vld_q       <= vld_d;
            rdy_q       <= rdy;
            asm_q       <= asm_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Pause suppresses write strobes and done pulses without touching state
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q & rdy;
    assign if_done   = if_done_q & rdy;
    assign mem_done  = mem_done_q & rdy;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req, mem_we, mem_signed;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int checks   = 0;
    int failures = 0;
    bit run_mon  = 1'b0;

    mem_arbiter #(.ADDR_W(32), .MEM_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // RAM: fixed contents at a few addresses, pattern elsewhere, writes overlay
    logic [7:0]  wmem [int unsigned];
    int unsigned wcnt [int unsigned];

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h00;
            32'h103: return 8'h00;
            32'h200: return 8'h80;
            32'h201: return 8'h12;
            32'h202: return 8'h34;
            32'h203: return 8'h56;
            32'h300: return 8'h11;
            32'h301: return 8'h22;
            32'h302: return 8'h33;
            32'h303: return 8'h44;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic int unsigned wc(input logic [31:0] a);
        return wcnt.exists(a) ? wcnt[a] : 0;
    endfunction

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : rom_byte(a);
    endfunction

    always @(posedge clk) begin
        ram_din <= rd_mem(ram_a);
        if (ram_wr === 1'b1) begin
            wmem[ram_a] = ram_dout;
            wcnt[ram_a] = wc(ram_a) + 1;
        end
    end

    // The two done pulses must never coincide
    always @(negedge clk) begin
        if (run_mon) begin
            checks++;
            if ((if_done & mem_done) !== 1'b0) begin
                failures++;
                $display("FAIL done_overlap got=%b exp=0", if_done & mem_done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (ram_a !== 32'h0) begin failures++; $display("FAIL reset_ram_a got=%h exp=0", ram_a); end
        checks++; if (ram_wr !== 1'b0) begin failures++; $display("FAIL reset_ram_wr got=%b exp=0", ram_wr); end
        checks++; if (ram_dout !== 8'h0) begin failures++; $display("FAIL reset_ram_dout got=%h exp=0", ram_dout); end
        checks++; if ({if_done, mem_done} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {if_done, mem_done}); end
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
        checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                checks++;
                if (ram_a !== 32'h100 + 32'(c - 1) || ram_wr !== 1'b0) begin
                    failures++; $display("FAIL fetch_bus c=%0d got a=%h wr=%b exp a=%h wr=0", c, ram_a, ram_wr, 32'h100 + 32'(c - 1));
                end
            end
            checks++;
            if (if_done !== (c == 6)) begin failures++; $display("FAIL fetch_done c=%0d got=%b exp=%b", c, if_done, c == 6); end
        end
        checks++; if (if_inst !== 32'h00000513) begin failures++; $display("FAIL fetch_inst got=%h exp=00000513", if_inst); end
        if_req = 1'b0;
        tick();
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_single_pulse got=%b exp=0", if_done); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h300;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_size = 2'd0; mem_signed = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                checks++; if (ram_a !== 32'h200) begin failures++; $display("FAIL prio_ram_a got=%h exp=00000200", ram_a); end
            end
            checks++; if (mem_done !== (c == 3)) begin failures++; $display("FAIL prio_mem_done c=%0d got=%b exp=%b", c, mem_done, c == 3); end
            checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL prio_if_done c=%0d got=%b exp=0", c, if_done); end
        end
        checks++; if (mem_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", mem_rdata); end
        mem_req = 1'b0;
        for (int c = 4; c <= 10; c++) begin
            tick();
            if (c == 5) begin
                checks++; if (ram_a !== 32'h300) begin failures++; $display("FAIL prio_if_after_a got=%h exp=00000300", ram_a); end
            end
            checks++; if (if_done !== (c == 10)) begin failures++; $display("FAIL prio_if_done2 c=%0d got=%b exp=%b", c, if_done, c == 10); end
        end
        checks++; if (if_inst !== 32'h44332211) begin failures++; $display("FAIL prio_if_inst got=%h exp=44332211", if_inst); end
        if_req = 1'b0;
        tick();
        mem_req = 1'b1; mem_signed = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (mem_done !== (c == 3)) begin failures++; $display("FAIL lbu_done c=%0d got=%b exp=%b", c, mem_done, c == 3); end
        end
        checks++; if (mem_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", mem_rdata); end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000; mem_size = 2'd2; mem_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                checks++;
                if (ram_wr !== 1'b1 || ram_a !== 32'h1000 + 32'(c - 1) || ram_dout !== exp_b[c - 1]) begin
                    failures++;
                    $display("FAIL sw_beat c=%0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", c, ram_wr, ram_a, ram_dout, 32'h1000 + 32'(c - 1), exp_b[c - 1]);
                end
            end else begin
                checks++; if (ram_wr !== 1'b0) begin failures++; $display("FAIL sw_wr_end got=%b exp=0", ram_wr); end
            end
            checks++; if (mem_done !== (c == 5)) begin failures++; $display("FAIL sw_done c=%0d got=%b exp=%b", c, mem_done, c == 5); end
        end
        checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", mem_rdata); end
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wc(32'h1000 + 32'(i)) != 1 || rd_mem(32'h1000 + 32'(i)) !== exp_b[i]) begin
                failures++;
                $display("FAIL sw_ram i=%0d got cnt=%0d d=%h exp cnt=1 d=%h", i, wc(32'h1000 + 32'(i)), rd_mem(32'h1000 + 32'(i)), exp_b[i]);
            end
        end
    endtask

    task automatic test_half();
        logic [31:0] exp_v;
        for (int v = 0; v < 2; v++) begin
            exp_v = (v == 0) ? 32'hFFFFDEAD : 32'h0000DEAD;
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1002; mem_size = 2'd1; mem_signed = (v == 0);
            for (int c = 1; c <= 4; c++) begin
                tick();
                checks++; if (mem_done !== (c == 4)) begin failures++; $display("FAIL half_done v=%0d c=%0d got=%b exp=%b", v, c, mem_done, c == 4); end
            end
            checks++; if (mem_rdata !== exp_v) begin failures++; $display("FAIL half_data v=%0d got=%h exp=%h", v, mem_rdata, exp_v); end
            mem_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL flush_early_done c=%0d got=%b exp=0", c, if_done); end
        end
        flush = 1'b1; if_addr = 32'h200;
        tick();
        checks++; if (if_done !== 1'b0 || ram_wr !== 1'b0) begin failures++; $display("FAIL flush_abort got done=%b wr=%b exp 0 0", if_done, ram_wr); end
        checks++; if (ram_a !== 32'h101) begin failures++; $display("FAIL flush_ram_hold got=%h exp=00000101", ram_a); end
        flush = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            tick();
            if (c == 4) begin
                checks++; if (ram_a !== 32'h200) begin failures++; $display("FAIL flush_refetch_a got=%h exp=00000200", ram_a); end
            end
            checks++; if (if_done !== (c == 9)) begin failures++; $display("FAIL flush_refetch_done c=%0d got=%b exp=%b", c, if_done, c == 9); end
        end
        checks++; if (if_inst !== 32'h56341280) begin failures++; $display("FAIL flush_refetch_inst got=%h exp=56341280", if_inst); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_pause_store();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h30; mem_size = 2'd1; mem_wdata = 32'h00001234;
        tick();
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h30 || ram_dout !== 8'h34) begin failures++; $display("FAIL sh_beat0 got wr=%b a=%h d=%h exp 1 30 34", ram_wr, ram_a, ram_dout); end
        rdy = 1'b0;
        #1;
        checks++; if (ram_wr !== 1'b0) begin failures++; $display("FAIL sh_pause_wr0 got=%b exp=0", ram_wr); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if (ram_wr !== 1'b0 || mem_done !== 1'b0 || ram_a !== 32'h30) begin failures++; $display("FAIL sh_paused c=%0d got wr=%b done=%b a=%h exp 0 0 30", c, ram_wr, mem_done, ram_a); end
        end
        rdy = 1'b1;
        #1;
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h30 || ram_dout !== 8'h34) begin failures++; $display("FAIL sh_resume got wr=%b a=%h d=%h exp 1 30 34", ram_wr, ram_a, ram_dout); end
        tick();
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h31 || ram_dout !== 8'h12) begin failures++; $display("FAIL sh_beat1 got wr=%b a=%h d=%h exp 1 31 12", ram_wr, ram_a, ram_dout); end
        tick();
        checks++; if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin failures++; $display("FAIL sh_done got done=%b wr=%b exp 1 0", mem_done, ram_wr); end
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        checks++; if (wc(32'h30) != 1 || wc(32'h31) != 1 || wc(32'h32) != 0) begin failures++; $display("FAIL sh_write_once got %0d %0d %0d exp 1 1 0", wc(32'h30), wc(32'h31), wc(32'h32)); end
        checks++; if (rd_mem(32'h30) !== 8'h34 || rd_mem(32'h31) !== 8'h12) begin failures++; $display("FAIL sh_ram got %h %h exp 34 12", rd_mem(32'h30), rd_mem(32'h31)); end
    endtask

    task automatic test_pause_load();
        bit seen = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_size = 2'd2; mem_signed = 1'b0;
        repeat (3) tick();
        rdy = 1'b0;
        repeat (2) begin
            tick();
            checks++; if (ram_wr !== 1'b0 || mem_done !== 1'b0) begin failures++; $display("FAIL lw_paused got wr=%b done=%b exp 0 0", ram_wr, mem_done); end
        end
        rdy = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (mem_done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL lw_pause_done got=timeout exp=done"); end
        checks++; if (mem_rdata !== 32'h44332211) begin failures++; $display("FAIL lw_pause_data got=%h exp=44332211", mem_rdata); end
        mem_req = 1'b0;
        tick();
        checks++; if (mem_done !== 1'b0 || wc(32'h300) != 0) begin failures++; $display("FAIL lw_pause_after got done=%b writes=%0d exp 0 0", mem_done, wc(32'h300)); end
    endtask

    task automatic test_reset_mid();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_size = 2'd2; mem_signed = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++; if (ram_a !== 32'h0 || ram_wr !== 1'b0 || ram_dout !== 8'h0) begin failures++; $display("FAIL rstmid_bus got a=%h wr=%b d=%h exp 0 0 0", ram_a, ram_wr, ram_dout); end
        checks++; if (if_inst !== 32'h0 || mem_rdata !== 32'h0 || mem_done !== 1'b0) begin failures++; $display("FAIL rstmid_out got inst=%h rdata=%h done=%b exp 0 0 0", if_inst, mem_rdata, mem_done); end
        repeat (2) begin
            tick();
            checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", mem_done); end
        end
        rst = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++; if (mem_done !== (c == 6)) begin failures++; $display("FAIL rstmid_reissue c=%0d got=%b exp=%b", c, mem_done, c == 6); end
        end
        checks++; if (mem_rdata !== 32'h44332211) begin failures++; $display("FAIL rstmid_data got=%h exp=44332211", mem_rdata); end
        mem_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_size = '0; mem_signed = 1'b0; mem_wdata = '0;
        test_reset();
        run_mon = 1'b1;
        test_if_fetch();
        test_priority();
        test_store();
        test_half();
        test_flush();
        test_pause_store();
        test_pause_load();
        test_reset_mid();
        run_mon = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
